uart_rx_engine: RTL and testbench
=================================

// Module: uart_rx_engine
// PURPOSE
//  UART receive engine for the UART peripheral on the processor I/O bus.
//  Samples the serial rx line mid-bit and assembles 7/8 data bits with optional parity.
//  Presents the byte on data and the flags on status for processor reads.
//  Format (eight, pen, even) and baud select come from the UART control register.
// PARAMETERS
//  CLK_HZ    100_000_000  system clock frequency; bit-time table below is for this value
//  RX_ADDR   16'h0000     port_id of RX data register; read clears RXRDY
//  STAT_ADDR 16'h0001     port_id of status register; read clears FERR/PERR/OVF
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-low reset
//  read_strobe  in   1   1-cycle processor read pulse, qualified by port_id
//  rx           in   1   serial input, idle high (synchronise with 2 flops internally)
//  eight        in   1   1 = 8 data bits, 0 = 7 data bits
//  pen          in   1   parity enable
//  clr          in   1   synchronous clear of all flags and the FSM (returns to IDLE)
//  even         in   1   1 = even parity, 0 = odd parity (used only when pen=1)
//  baud         in   4   baud select (see BEHAVIOUR)
//  port_id      in   16  processor port address
//  data         out  8   received byte; bit7 forced 0 when eight=0
//  status       out  8   {4'b0, OVF, FERR, PERR, RXRDY}
//  RXRDY        out  1   byte available
//  FERR         out  1   stop bit sampled low
//  PERR         out  1   parity mismatch
//  OVF          out  1   new frame completed while RXRDY still set
// BEHAVIOUR
//  Reset / clr: FSM=IDLE, counters 0, data=0; RXRDY, FERR, PERR, OVF = 0.
//  Bit time BT in clocks by baud:
//   0:333333  1:83333  2:41667  3:20833  4:10417  5:5208
//   6:2604    7:1736   8:868    9:434    10:217   11..15:109
//  Frame length N = 1 start + (eight?8:7) data + (pen?1:0) parity + 1 stop.
//  FSM states:
//   IDLE:  on synchronised rx falling to 0 -> START, load counter with BT/2.
//   START: at counter expiry, sample rx.
//          If rx=1, false start: -> IDLE, no flag change.
//          Else reload counter with BT -> DATA, bit index = 1.
//   DATA:  at each expiry, shift rx into a 10-bit right-shift register.
//          Increment index; reload BT. When index reaches N -> DONE.
//          The last sample taken is the stop bit.
//   DONE (1 cycle): right-justify the frame per eight/pen.
//          data = data bits, LSB first on the wire.
//          PERR set if pen and (^data_bits ^ parity_bit) != (even?0:1).
//          FERR set if stop sample = 0.
//          OVF set if RXRDY already 1.
//          RXRDY <= 1; data register is overwritten; -> IDLE.
//  Flags are sticky until cleared:
//   read_strobe && port_id==RX_ADDR clears RXRDY the next cycle.
//   read_strobe && port_id==STAT_ADDR clears FERR, PERR, OVF.
//  A set in DONE and a clearing read in the same cycle: the set wins.
//  Format and baud inputs are sampled continuously.
//  Changing them mid-frame is undefined but must not hang the FSM; it always returns to IDLE.
//  rx glitch shorter than BT/2 is rejected as a false start.
// TESTING
//  1 Reset low with rx=0 -> all outputs 0.
//    Release, rx=1 -> FSM stays IDLE, RXRDY=0.
//  2 baud=11, rx low 20 ns then high -> false start, no RXRDY/FERR/PERR/OVF.
//  3 baud=11, eight=1, pen=0: send 0xA5 with stop=1.
//    -> RXRDY=1, data=8'hA5, status=8'h01 about 10*109 clocks after start edge.
//  4 eight=0, pen=1, even=1: send 7'h41 with parity bit 1 -> PERR=1, data=8'h41.
//    Same frame with correct parity 0 -> PERR=0.
//  5 Send 0x3C with stop bit 0 -> FERR=1, RXRDY=1.
//    Read at STAT_ADDR -> FERR=0; read at RX_ADDR -> RXRDY=0.
//  6 Send two frames (0x11, 0x22) without reading -> OVF=1, data=8'h22.
//    Assert clr -> all flags 0.

Source files
------------

// File: rtl/uart_rx_engine.sv
// UART receive engine: mid-bit sampling of a synchronised rx line, 7/8 data bits with
// optional parity, sticky RXRDY/FERR/PERR/OVF flags cleared by processor reads or clr.
module uart_rx_engine #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter logic [15:0] RX_ADDR   = 16'h0000,
  parameter logic [15:0] STAT_ADDR = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_strobe,
  input  logic        rx,
  input  logic        eight,
  input  logic        pen,
  input  logic        clr,
  input  logic        even,
  input  logic [3:0]  baud,
  input  logic [15:0] port_id,
  output logic [7:0]  data,
  output logic [7:0]  status,
  output logic        RXRDY,
  output logic        FERR,
  output logic        PERR,
  output logic        OVF
);

  // Bit times are rounded CLK_HZ/rate for 300..921600 baud; selects above 11 share the fastest rate.
  localparam logic [19:0] BT_TAB [12] = '{
    20'((CLK_HZ + 150) / 300),       20'((CLK_HZ + 600) / 1200),
    20'((CLK_HZ + 1200) / 2400),     20'((CLK_HZ + 2400) / 4800),
    20'((CLK_HZ + 4800) / 9600),     20'((CLK_HZ + 9600) / 19200),
    20'((CLK_HZ + 19200) / 38400),   20'((CLK_HZ + 28800) / 57600),
    20'((CLK_HZ + 57600) / 115200),  20'((CLK_HZ + 115200) / 230400),
    20'((CLK_HZ + 230400) / 460800), 20'((CLK_HZ + 460800) / 921600)
  };

  function automatic logic [19:0] bit_time(input logic [3:0] sel);
    return BT_TAB[(sel > 4'd11) ? 4'd11 : sel];
  endfunction

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  state_t      state;
  logic [19:0] cnt;
  logic [3:0]  idx;
  logic [9:0]  sr;
  logic        rx_p0, rx_p1, rx_p2;
  logic [3:0]  nsamp;
  logic [9:0]  frame;
  logic [7:0]  dbits;
  logic        par_bit;
  logic        par_err;
  logic        rd_rx, rd_stat;
  logic        expired;

  // Stage p0/p1: two-flop synchroniser; p2 holds the previous synchronised level for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Samples after the start bit sit at the top of sr; shift them down to bit 0.
  always_comb begin
    nsamp   = (eight ? 4'd8 : 4'd7) + {3'b000, pen} + 4'd1;
    frame   = sr >> (4'd10 - nsamp);
    dbits   = eight ? frame[7:0] : {1'b0, frame[6:0]};
    par_bit = eight ? frame[8] : frame[7];
    par_err = pen && ((^dbits ^ par_bit) != !even);
    rd_rx   = read_strobe && (port_id == RX_ADDR);
    rd_stat = read_strobe && (port_id == STAT_ADDR);
    expired = (cnt <= 20'd1);
  end

  assign status = {4'b0000, OVF, FERR, PERR, RXRDY};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sr    <= '0;
      data  <= '0;
      RXRDY <= 1'b0;
      FERR  <= 1'b0;
      PERR  <= 1'b0;
      OVF   <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sr    <= '0;
      data  <= '0;
      RXRDY <= 1'b0;
      FERR  <= 1'b0;
      PERR  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      if (rd_rx) RXRDY <= 1'b0;
      if (rd_stat) begin
        FERR <= 1'b0;
        PERR <= 1'b0;
        OVF  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rx_p2 && !rx_p1) begin
            cnt   <= bit_time(baud) >> 1;
            state <= START;
          end
        end
        START: begin
          if (expired) begin
            if (rx_p1) begin
              state <= IDLE;
            end else begin
              cnt   <= bit_time(baud);
              idx   <= 4'd1;
              state <= DATA;
            end
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        DATA: begin
          // The >= comparison keeps the FSM bounded if the format shrinks mid-frame.
          if (expired) begin
            sr  <= {rx_p1, sr[9:1]};
            idx <= idx + 4'd1;
            cnt <= bit_time(baud);
            if (idx >= nsamp) state <= DONE;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        DONE: begin
          // Placed after the read clears so a same-cycle set takes priority.
          data  <= dbits;
          RXRDY <= 1'b1;
          if (par_err) PERR <= 1'b1;
          if (!sr[9])  FERR <= 1'b1;
          if (RXRDY)   OVF  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine at baud select 11 (109 clocks per bit at 100 MHz).
module tb_uart_rx_engine;
  localparam int BT = 109;

  logic        clk = 1'b0;
  logic        rst, read_strobe, rx, eight, pen, clr, even;
  logic [3:0]  baud;
  logic [15:0] port_id;
  logic [7:0]  data, status;
  logic        RXRDY, FERR, PERR, OVF;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  logic        prev_rdy = 1'b0;
  logic        prev_ovf = 1'b0;

  uart_rx_engine dut (
    .clk(clk), .rst(rst), .read_strobe(read_strobe), .rx(rx), .eight(eight),
    .pen(pen), .clr(clr), .even(even), .baud(baud), .port_id(port_id),
    .data(data), .status(status), .RXRDY(RXRDY), .FERR(FERR), .PERR(PERR), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a frame completion shows as RXRDY rising, or OVF rising when RXRDY was still set.
  always @(negedge clk) begin
    if (rst && ((RXRDY && !prev_rdy) || (OVF && !prev_ovf))) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got data=%h status=%h expected none", data, status);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", {8'h00, data}, {8'h00, e[15:8]});
        check("frame_status", {8'h00, status}, {8'h00, e[7:0]});
      end
    end
    prev_rdy <= RXRDY;
    prev_ovf <= OVF;
  end

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic [15:0] expect_val);
    exp_q.push_back(expect_val);
    @(negedge clk);
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < (eight ? 8 : 7); i++) begin
      rx = d[i];
      repeat (BT) @(negedge clk);
    end
    if (pen) begin
      rx = par;
      repeat (BT) @(negedge clk);
    end
    rx = stop;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic rd(input logic [15:0] addr);
    @(negedge clk);
    port_id     = addr;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx = 1'b0; read_strobe = 1'b0; clr = 1'b0;
    eight = 1'b1; pen = 1'b0; even = 1'b1; baud = 4'd11; port_id = 16'h0000;
    repeat (5) @(negedge clk);
    check("reset_data_status", {data, status}, 16'h0000);
    check("reset_flags", {12'h000, RXRDY, FERR, PERR, OVF}, 16'h0000);

    rx  = 1'b1;
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("idle_after_release", {8'h00, status}, 16'h0000);

    // Glitch of two clocks is far shorter than BT/2.
    @(negedge clk);
    rx = 1'b0;
    #20;
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("false_start_status", {8'h00, status}, 16'h0000);
    check("false_start_data", {8'h00, data}, 16'h0000);

    send_frame(8'hA5, 1'b0, 1'b1, {8'hA5, 8'h01});
    wait_drain();
    rd(16'h0000);

    eight = 1'b0; pen = 1'b1; even = 1'b1;
    send_frame(8'h41, 1'b1, 1'b1, {8'h41, 8'h03});
    wait_drain();
    rd(16'h0000);
    rd(16'h0001);
    check("flags_cleared_by_reads", {8'h00, status}, 16'h0000);
    send_frame(8'h41, 1'b0, 1'b1, {8'h41, 8'h01});
    wait_drain();
    rd(16'h0000);

    eight = 1'b1; pen = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, {8'h3C, 8'h05});
    wait_drain();
    rd(16'h0001);
    check("ferr_cleared_by_stat_read", {8'h00, status}, 16'h0001);
    rd(16'h0000);
    check("rxrdy_cleared_by_rx_read", {8'h00, status}, 16'h0000);

    send_frame(8'h11, 1'b0, 1'b1, {8'h11, 8'h01});
    send_frame(8'h22, 1'b0, 1'b1, {8'h22, 8'h09});
    wait_drain();
    check("ovf_held_data", {data, status}, 16'h2209);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_status", {8'h00, status}, 16'h0000);
    check("clr_data", {8'h00, data}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
